// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins plus the digit-buffer / key-event bus.
// master: the scanner (drives key_col and all key/buffer outputs, takes key_row and clear).
// slave:  the board/CPU side (drives key_row and clear, observes everything else).
interface keypad_scanner_if;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic        clear;
    logic [31:0] input_data;
    logic [7:0]  input_valid;
    logic [3:0]  key_code;
    logic        key_strobe;
    logic        key_pressed;

    modport master (
        input  key_row, clear,
        output key_col, input_data, input_valid, key_code, key_strobe, key_pressed
    );

    modport slave (
        output key_row, clear,
        input  key_col, input_data, input_valid, key_code, key_strobe, key_pressed
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and a hex digit buffer.
// Ports: clk (rising edge), rst (async active-low),
//        bus (keypad_scanner_if.master): key_row in (active-low rows), key_col out
//        (one-hot active-low), clear in, input_data/input_valid/key_code/key_strobe/key_pressed out.
// Optional feature: define KEYPAD_BACKSPACE_EN to make key code F delete the newest digit.
module keypad_scanner #(
    parameter int SCAN_DIV       = 250000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rst,
    keypad_scanner_if.master bus
);
    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic [3:0]    sync1, sync2, pat, cnt;
    logic [1:0]    col, row_idx;
    logic          tick;

    assign tick = div == DIV_MAX;

    // Lowest-numbered low row wins when several keys in one column are down.
    always_comb row_idx = !sync2[0] ? 2'd0 : !sync2[1] ? 2'd1 : !sync2[2] ? 2'd2 : 2'd3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            div             <= '0;
            sync1           <= 4'hF;
            sync2           <= 4'hF;
            pat             <= 4'hF;
            cnt             <= '0;
            col             <= '0;
            bus.key_col     <= 4'b1110;
            bus.input_data  <= '0;
            bus.input_valid <= '0;
            bus.key_code    <= '0;
            bus.key_strobe  <= 1'b0;
            bus.key_pressed <= 1'b0;
        end else begin
            div            <= tick ? '0 : div + 1'b1;
            sync1          <= bus.key_row;
            sync2          <= sync1;
            bus.key_strobe <= 1'b0;
            case (state)
                IDLE: if (tick) begin
                    // The column only moves on while the rows read idle, so a
                    // detected press is always attributed to the driven column.
                    if (sync2 != 4'hF) begin
                        state <= DEBOUNCE;
                        pat   <= sync2;
                        cnt   <= 4'd1;
                    end else begin
                        col         <= col + 2'd1;
                        bus.key_col <= ~(4'b1 << (col + 2'd1));
                    end
                end
                DEBOUNCE: if (tick) begin
                    if (sync2 == 4'hF)
                        state <= IDLE;
                    else if (sync2 == pat) begin
                        if (cnt >= DB_LAST) begin
                            state           <= PRESSED;
                            bus.key_strobe  <= 1'b1;
                            bus.key_code    <= {row_idx, col};
                            bus.key_pressed <= 1'b1;
                        end else
                            cnt <= cnt + 4'd1;
                    end else begin
                        pat <= sync2;
                        cnt <= 4'd1;
                    end
                end
                PRESSED: begin
                    state <= RELEASE;
                    cnt   <= '0;
`ifdef KEYPAD_BACKSPACE_EN
                    if (bus.key_code == 4'hF) begin
                        bus.input_data  <= {4'h0, bus.input_data[31:4]};
                        bus.input_valid <= {1'b0, bus.input_valid[7:1]};
                    end else begin
                        bus.input_data  <= {bus.input_data[27:0], bus.key_code};
                        bus.input_valid <= {bus.input_valid[6:0], 1'b1};
                    end
`else
                    bus.input_data  <= {bus.input_data[27:0], bus.key_code};
                    bus.input_valid <= {bus.input_valid[6:0], 1'b1};
`endif
                end
                RELEASE: if (tick) begin
                    if (sync2 != 4'hF)
                        cnt <= '0;
                    else if (cnt >= DB_LAST) begin
                        state           <= IDLE;
                        bus.key_pressed <= 1'b0;
                    end else
                        cnt <= cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
            // Placed last so a clear overrides a shift in the same cycle.
            if (bus.clear) begin
                bus.input_data  <= '0;
                bus.input_valid <= '0;
            end
        end
    end
endmodule
